// File: rtl/operand_forward_ctrl.sv
// EX-stage operand forwarding controller: tracks in-flight destinations, registers
// forward selects at issue, and raises stall (load-use, multi-cycle EX) and flush.
module operand_forward_ctrl #(
    parameter int REG_BITS = 5,
    parameter int MC_LAT   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_multi,
    input  logic                ex_branch_taken,
    output logic                Fa,
    output logic                Fb,
    output logic                srcA,
    output logic                srcB,
    output logic                stall,
    output logic                flush,
    output logic                busy
);

    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

    // Forwarding only ever selects a producer in EX or MEM at issue time, so the
    // WB occupant never needs storing: it has already written the register file.
    logic                ex_valid_q, ex_valid_d;
    logic [REG_BITS-1:0] ex_rd_q, ex_rd_d;
    logic                ex_rw_q, ex_rw_d;
    logic                ex_mr_q, ex_mr_d;
    logic                mem_wr_q, mem_wr_d;
    logic [REG_BITS-1:0] mem_rd_q, mem_rd_d;
    logic [3:0]          mc_cnt_q, mc_cnt_d;
    logic                fa_q, fa_d, fb_q, fb_d;
    logic                sa_q, sa_d, sb_q, sb_d;

    logic busy_s, flush_s, stall_s, issue_s, load_use_s;
    logic hit_ex_a_s, hit_ex_b_s, hit_mem_a_s, hit_mem_b_s;

    function automatic logic src_hit(input logic                wr,
                                     input logic [REG_BITS-1:0] rd,
                                     input logic [REG_BITS-1:0] rs,
                                     input logic                used);
        return used & (rs != '0) & wr & (rd == rs);
    endfunction

    // Hazard detection and issue qualification
    always_comb begin
        hit_ex_a_s  = src_hit(ex_valid_q & ex_rw_q, ex_rd_q, id_rs1, id_rs1_used);
        hit_ex_b_s  = src_hit(ex_valid_q & ex_rw_q, ex_rd_q, id_rs2, id_rs2_used);
        hit_mem_a_s = src_hit(mem_wr_q, mem_rd_q, id_rs1, id_rs1_used);
        hit_mem_b_s = src_hit(mem_wr_q, mem_rd_q, id_rs2, id_rs2_used);
        busy_s      = (mc_cnt_q != 4'd0);
        flush_s     = ex_branch_taken & ~busy_s;
        load_use_s  = id_valid & ex_mr_q & (hit_ex_a_s | hit_ex_b_s);
        stall_s     = busy_s | (load_use_s & ~flush_s);
        issue_s     = id_valid & ~stall_s & ~flush_s;
    end

    // Next-state: freeze everything during the multi-cycle hold, otherwise advance
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        ex_rw_d    = ex_rw_q;
        ex_mr_d    = ex_mr_q;
        mem_wr_d   = mem_wr_q;
        mem_rd_d   = mem_rd_q;
        fa_d       = fa_q;
        fb_d       = fb_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        mc_cnt_d   = mc_cnt_q;
        if (busy_s) begin
            mc_cnt_d = mc_cnt_q - 4'd1;
        end else begin
            ex_valid_d = issue_s;
            ex_rd_d    = issue_s ? id_rd : '0;
            ex_rw_d    = issue_s & id_reg_write;
            ex_mr_d    = issue_s & id_mem_read;
            mem_wr_d   = ex_valid_q & ex_rw_q;
            mem_rd_d   = ex_rd_q;
            // EX match wins over MEM: it holds the newer value
            fa_d       = issue_s & (hit_ex_a_s | hit_mem_a_s);
            fb_d       = issue_s & (hit_ex_b_s | hit_mem_b_s);
            sa_d       = issue_s & ~hit_ex_a_s & hit_mem_a_s;
            sb_d       = issue_s & ~hit_ex_b_s & hit_mem_b_s;
            mc_cnt_d   = (issue_s & id_multi) ? MC_LOAD : 4'd0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_rw_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= '0;
            mc_cnt_q   <= 4'd0;
            fa_q       <= 1'b0;
            fb_q       <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            ex_rw_q    <= ex_rw_d;
            ex_mr_q    <= ex_mr_d;
            mem_wr_q   <= mem_wr_d;
            mem_rd_q   <= mem_rd_d;
            mc_cnt_q   <= mc_cnt_d;
            fa_q       <= fa_d;
            fb_q       <= fb_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
        end
    end

    assign Fa    = fa_q;
    assign Fb    = fb_q;
    assign srcA  = sa_q;
    assign srcB  = sb_q;
    assign stall = stall_s;
    assign flush = flush_s;
    assign busy  = busy_s;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Scoreboard bench for operand_forward_ctrl: directed hazard scenarios then random
// traffic, checked against a queue-of-instructions pipeline model.
module tb_operand_forward_ctrl;

    localparam int RB     = 5;
    localparam int MC_LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, id_multi;
    logic [RB-1:0] id_rs1, id_rs2, id_rd;
    logic          ex_branch_taken;
    logic          Fa, Fb, srcA, srcB, stall, flush, busy;

    operand_forward_ctrl #(.REG_BITS(RB), .MC_LAT(MC_LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multi(id_multi),
        .ex_branch_taken(ex_branch_taken), .Fa(Fa), .Fb(Fb), .srcA(srcA), .srcB(srcB),
        .stall(stall), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {bit v; int rd; bit rw; bit mr;} ins_t;
    typedef struct {bit stall; bit flush; bit busy; bit fa; bit fb; bit sa; bit sb;} exp_t;

    ins_t pipe[$];      // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
    int   hold_left;
    bit   m_fa, m_fb, m_sa, m_sb;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stall_cycles = 0;

    function automatic void model_reset();
        ins_t b = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
        pipe = {b, b, b};
        hold_left = 0;
        {m_fa, m_fb, m_sa, m_sb} = 4'b0000;
    endfunction

    // Newest in-flight writer of rs among EX/MEM: f=found, s=stage index (0 EX, 1 MEM)
    function automatic void producer(input int rs, input bit used, output bit f, output bit s);
        f = 1'b0; s = 1'b0;
        if (used && rs != 0) begin
            for (int k = 0; k < 2; k++) begin
                if (!f && pipe[k].v && pipe[k].rw && pipe[k].rd == rs) begin
                    f = 1'b1;
                    s = (k == 1);
                end
            end
        end
    endfunction

    function automatic void check(input string name, input bit act, input bit exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of stimulus, predict outputs, then advance the model at the edge
    task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit mr, input bit mul,
                        input bit br, input bit r);
        exp_t e;
        bit   lu, iss, f1, s1, f2, s2;
        id_valid = v;  id_rs1 = RB'(rs1); id_rs2 = RB'(rs2);
        id_rs1_used = u1; id_rs2_used = u2; id_rd = RB'(rd);
        id_reg_write = rw; id_mem_read = mr; id_multi = mul;
        ex_branch_taken = br; rst = r;
        e.busy  = (hold_left > 0);
        e.flush = br && !e.busy;
        lu = v && pipe[0].v && pipe[0].mr && pipe[0].rw &&
             ((u1 && rs1 != 0 && rs1 == pipe[0].rd) || (u2 && rs2 != 0 && rs2 == pipe[0].rd));
        e.stall = e.busy || (lu && !e.flush);
        e.fa = m_fa; e.fb = m_fb; e.sa = m_sa; e.sb = m_sb;
        exp_q.push_back(e);
        iss = v && !e.stall && !e.flush;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (hold_left > 0) begin
            hold_left--;
        end else begin
            ins_t n;
            producer(rs1, u1, f1, s1);
            producer(rs2, u2, f2, s2);
            m_fa = iss && f1; m_sa = iss && f1 && s1;
            m_fb = iss && f2; m_sb = iss && f2 && s2;
            n = '{v: iss, rd: iss ? rd : 0, rw: iss && rw, mr: iss && mr};
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (iss && mul) hold_left = MC_LAT - 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents outputs; pop the prediction and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", stall, e.stall);
                check("flush", flush, e.flush);
                check("busy",  busy,  e.busy);
                check("Fa",    Fa,    e.fa);
                check("Fb",    Fb,    e.fb);
                check("srcA",  srcA,  e.sa);
                check("srcB",  srcB,  e.sb);
                if (stall) stall_cycles++;
            end
        end
    end

    initial begin
        int bound;
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
        id_rs2_used = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_multi = 1'b0; ex_branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        idle(2);
        // EX->EX forwarding: add x3 ; add x4,x3,x5
        step(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
        step(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0);
        idle(2);
        // MEM forwarding: add x3 ; unrelated ; sub x6,x1,x3
        step(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
        step(1, 1, 1, 2, 1, 10, 1, 0, 0, 0, 0);
        step(1, 1, 1, 3, 1, 6, 1, 0, 0, 0, 0);
        idle(2);
        // Load-use: lw x7 ; add x8,x7,x7 (held while stalled)
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0);
        idle(2);
        // x0 never forwards; double writer of x9 picks EX
        step(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 11, 1, 0, 0, 0, 0);
        step(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0);
        step(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0);
        step(1, 9, 1, 9, 1, 12, 1, 0, 0, 0, 0);
        idle(2);
        // Multi-cycle op then a waiting consumer of its result
        step(1, 1, 1, 2, 1, 13, 1, 0, 1, 0, 0);
        repeat (4) step(1, 13, 1, 2, 1, 14, 1, 0, 0, 0, 0);
        idle(2);
        // Branch beats load-use stall
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1, 0);
        idle(2);
        // Reset while busy
        step(1, 1, 1, 2, 1, 13, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // Random traffic over a small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            bit rw, mr;
            rw = ($urandom_range(0, 3) != 0);
            mr = rw && ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 7), rw, mr,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 199) == 0);
        end
        bound = 0;
        while (exp_q.size() > 0 && bound < 10) begin
            @(negedge clk);
            bound++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        n_checks++;
        if (stall_cycles == 0) begin
            n_fail++;
            $display("FAIL stall_seen: got %0d stall cycles, expected nonzero", stall_cycles);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
